// File: rtl/io_port_bank_pkg.sv
// io_port_bank_pkg: shared constants, address-select type and the address
// decoder used by the I/O port bank.
//   IO_DW / IO_NP / IO_AW  default data width, port count, address width
//   ADDR_STATUS / ADDR_OVF register addresses above the data ports
//   decode_addr()          classifies an I/O address into a register select
package io_port_bank_pkg;

  localparam int unsigned IO_DW       = 32'd8;
  localparam int unsigned IO_NP       = 32'd4;
  localparam int unsigned IO_AW       = 32'd3;
  localparam int unsigned ADDR_STATUS = 32'd4;
  localparam int unsigned ADDR_OVF    = 32'd5;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_DATA   = 2'd1,
    SEL_STATUS = 2'd2,
    SEL_OVF    = 2'd3
  } sel_e;

  // Data ports occupy 0..np-1; np never exceeds 4, so they cannot collide
  // with the status/overflow registers.
  function automatic sel_e decode_addr(input int unsigned addr, input int unsigned np);
    sel_e sel;
    if (addr < np) begin
      sel = SEL_DATA;
    end else if (addr == ADDR_STATUS) begin
      sel = SEL_STATUS;
    end else if (addr == ADDR_OVF) begin
      sel = SEL_OVF;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/io_port_bank_if.sv
// io_port_bank_if: processor I/O bus between the microcontroller and the
// port bank.
//   io_addr  port address          io_rd / io_wr  read / write this cycle
//   wr_data  processor write data  rd_data        zero-latency read data
// master = processor side, slave = peripheral side.
interface io_port_bank_if
  import io_port_bank_pkg::*;
#(
  parameter int unsigned AW = IO_AW,
  parameter int unsigned DW = IO_DW
) ();

  logic [AW-1:0] io_addr;
  logic          io_rd;
  logic          io_wr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;

  modport master (output io_addr, output io_rd, output io_wr, output wr_data,
                  input rd_data);
  modport slave  (input io_addr, input io_rd, input io_wr, input wr_data,
                  output rd_data);

endinterface

// File: rtl/io_port_bank_in_chan.sv
// io_port_bank_in_chan: one-entry capture buffer for a single input port.
//   clk, reset  clock and synchronous active-low reset
//   stb, din    external byte-valid strobe and byte
//   rd          processor is reading this port this cycle
//   dout        buffered byte (held after being read)
//   full        buffer holds an unread byte
//   drop        strobe arrived while full and not being read (byte lost)
module io_port_bank_in_chan #(
  parameter int unsigned DW = 32'd8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stb,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          drop
);

  logic [DW-1:0] buf_r;
  logic          full_r;

  // A read in the same cycle frees the slot, so a strobe is only lost when
  // the buffer is full and nobody is reading it.
  assign drop = stb & full_r & ~rd;
  assign dout = buf_r;
  assign full = full_r;

  // Capture buffer and full flag; a same-cycle strobe keeps the buffer full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_r  <= {DW{1'b0}};
      full_r <= 1'b0;
    end else begin
      if (stb && (!full_r || rd)) begin
        buf_r <= din;
      end else begin
        buf_r <= buf_r;
      end
      if (stb) begin
        full_r <= 1'b1;
      end else if (rd) begin
        full_r <= 1'b0;
      end else begin
        full_r <= full_r;
      end
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: peripheral-side responder decoding processor I/O reads and
// writes into NP input and NP output byte ports.
//   clk, reset  clock and synchronous active-low reset
//   bus         processor I/O bus (slave side)
//   in_port     input bytes, port i at [i*DW +: DW]; in_stb per-port valid
//   in_rdy      input buffer i empty
//   out_port    output holding registers; out_stb byte i pending
//   out_ack     external consumed output byte i
// Address map: 0..NP-1 data, 4 STATUS {in_full,out_pend}, 5 OVF read-to-clear.
module io_port_bank
  import io_port_bank_pkg::*;
#(
  parameter int unsigned DW = IO_DW,
  parameter int unsigned NP = IO_NP,
  parameter int unsigned AW = IO_AW
) (
  input  logic             clk,
  input  logic             reset,
  io_port_bank_if.slave    bus,
  input  logic [NP*DW-1:0] in_port,
  input  logic [NP-1:0]    in_stb,
  output logic [NP-1:0]    in_rdy,
  output logic [NP*DW-1:0] out_port,
  output logic [NP-1:0]    out_stb,
  input  logic [NP-1:0]    out_ack
);

  sel_e          sel_s;
  logic [NP-1:0] rd_port_s;
  logic [NP-1:0] wr_port_s;
  logic [NP-1:0] in_full_s;
  logic [NP-1:0] drop_s;
  logic [DW-1:0] in_dout_s [NP];
  logic [DW-1:0] out_reg_r [NP];
  logic [NP-1:0] out_pend_r;
  logic [NP-1:0] ovf_r;
  logic [3:0]    full4_s;
  logic [3:0]    pend4_s;
  logic [3:0]    ovf4_s;
  logic [DW-1:0] data_s;
  logic [DW-1:0] rd_s;
  logic          ovf_rd_s;

  assign sel_s    = decode_addr(32'(bus.io_addr), NP);
  assign ovf_rd_s = bus.io_rd & (sel_s == SEL_OVF);

  // Per-port read/write selects and the OR-mux of input buffer contents.
  always_comb begin
    rd_port_s = {NP{1'b0}};
    wr_port_s = {NP{1'b0}};
    data_s    = {DW{1'b0}};
    for (int i = 0; i < NP; i++) begin
      rd_port_s[i] = bus.io_rd & (sel_s == SEL_DATA) & (bus.io_addr == AW'(i));
      wr_port_s[i] = bus.io_wr & (sel_s == SEL_DATA) & (bus.io_addr == AW'(i));
      data_s       = data_s | ({DW{rd_port_s[i]}} & in_dout_s[i]);
    end
  end

  // Status/overflow fields are fixed at 4 bits; absent ports read as zero.
  always_comb begin
    full4_s = 4'b0000;
    pend4_s = 4'b0000;
    ovf4_s  = 4'b0000;
    for (int i = 0; i < NP; i++) begin
      full4_s[i] = in_full_s[i];
      pend4_s[i] = out_pend_r[i];
      ovf4_s[i]  = ovf_r[i];
    end
  end

  // Zero-latency read data mux; idle bus reads as zero.
  always_comb begin
    rd_s = {DW{1'b0}};
    if (bus.io_rd) begin
      case (sel_s)
        SEL_DATA:   rd_s = data_s;
        SEL_STATUS: rd_s = DW'({full4_s, pend4_s});
        SEL_OVF:    rd_s = DW'({4'b0000, ovf4_s});
        default:    rd_s = {DW{1'b0}};
      endcase
    end else begin
      rd_s = {DW{1'b0}};
    end
  end

  assign bus.rd_data = rd_s;

  for (genvar g = 0; g < NP; g++) begin : gen_port
    io_port_bank_in_chan #(.DW(DW)) u_in_chan (
      .clk  (clk),
      .reset(reset),
      .stb  (in_stb[g]),
      .din  (in_port[g*DW +: DW]),
      .rd   (rd_port_s[g]),
      .dout (in_dout_s[g]),
      .full (in_full_s[g]),
      .drop (drop_s[g])
    );
    assign in_rdy[g]            = ~in_full_s[g];
    assign out_port[g*DW +: DW] = out_reg_r[g];
    assign out_stb[g]           = out_pend_r[g];
  end

  // Output holding registers, pending flags and sticky overflow bits.
  // A write beats a same-cycle ack so freshly loaded data stays pending;
  // an overflow read keeps only drops that happen in that same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NP; i++) begin
        out_reg_r[i] <= {DW{1'b0}};
      end
      out_pend_r <= {NP{1'b0}};
      ovf_r      <= {NP{1'b0}};
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (wr_port_s[i]) begin
          out_reg_r[i]  <= bus.wr_data;
          out_pend_r[i] <= 1'b1;
        end else if (out_ack[i]) begin
          out_pend_r[i] <= 1'b0;
        end else begin
          out_pend_r[i] <= out_pend_r[i];
        end
      end
      if (ovf_rd_s) begin
        ovf_r <= drop_s;
      end else begin
        ovf_r <= ovf_r | drop_s;
      end
    end
  end

endmodule
